// File: rtl/output_writeback.sv
// output_writeback
// Writes the convolution result stream to external memory. Each result is
// registered together with its linear address (stage 1), then pushed into a
// small FIFO that absorbs memory stalls. The input stream cannot be stalled, so
// a result arriving while the FIFO is full is dropped and flagged.
//
// Ports:
//   clk, rst_in                 clock, synchronous active-high reset
//   start                       one-cycle pulse, clears state for a new map
//   in_data/in_valid            result value (signed) and its strobe
//   in_x/in_y/in_ch             result coordinates
//   mem_we/mem_addr/mem_wdata   write request to external memory (FIFO head)
//   mem_ready                   memory accepts the write this cycle
//   fifo_level                  registered FIFO occupancy
//   overflow                    sticky, a result was dropped
//   done                        level, all W*H*CH writes completed
//
// Optional feature macro: WRITEBACK_RELU_EN (negative results written as 0).
module output_writeback #(
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int EXT_MEM_HEIGHT     = 1 << 20,
  parameter int EXT_MEM_WIDTH      = 32,
  parameter int FEATURE_MAP_WIDTH  = 64,
  parameter int FEATURE_MAP_HEIGHT = 64,
  parameter int OUTPUT_NB_CHANNELS = 32,
  parameter int BASE_ADDR          = 0,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_in,
  input  logic                                    start,
  input  logic [ACCUMULATION_WIDTH-1:0]           in_data,
  input  logic                                    in_valid,
  input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    in_x,
  input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   in_y,
  input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   in_ch,
  output logic                                    mem_we,
  output logic [$clog2(EXT_MEM_HEIGHT)-1:0]       mem_addr,
  output logic [EXT_MEM_WIDTH-1:0]                mem_wdata,
  input  logic                                    mem_ready,
  output logic [$clog2(FIFO_DEPTH):0]             fifo_level,
  output logic                                    overflow,
  output logic                                    done
);

  localparam int ADDR_W  = $clog2(EXT_MEM_HEIGHT);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + EXT_MEM_WIDTH;
  localparam int TOTAL   = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS;
  localparam int CNT_W   = $clog2(TOTAL + 1);

  // Stage 1 inputs: address arithmetic is done in ADDR_W bits so it wraps
  // modulo the memory size; out-of-range coordinates simply alias.
  logic [ADDR_W-1:0]        addr_calc;
  logic [EXT_MEM_WIDTH-1:0] data_calc;

  always_comb begin
    addr_calc = ADDR_W'(BASE_ADDR)
              + (ADDR_W'(in_y) * ADDR_W'(FEATURE_MAP_WIDTH) + ADDR_W'(in_x))
                * ADDR_W'(OUTPUT_NB_CHANNELS)
              + ADDR_W'(in_ch);
`ifdef WRITEBACK_RELU_EN
    data_calc = in_data[ACCUMULATION_WIDTH-1] ? '0 : EXT_MEM_WIDTH'($signed(in_data));
`else
    data_calc = EXT_MEM_WIDTH'($signed(in_data));
`endif
  end

  logic                     s1_valid_reg;
  logic [ADDR_W-1:0]        s1_addr_reg;
  logic [EXT_MEM_WIDTH-1:0] s1_data_reg;

  // FIFO storage; shallow, so the head is read combinationally.
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [LVL_W-1:0]   level_reg;
  logic               overflow_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               done_reg;

  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               push;
  logic               drop;
  logic [ENTRY_W-1:0] head;

  always_comb begin
    fifo_empty = (level_reg == '0);
    fifo_full  = (level_reg == LVL_W'(FIFO_DEPTH));
    pop        = !fifo_empty && mem_ready;
    // A full FIFO still accepts a push when its head leaves in the same cycle.
    push       = s1_valid_reg && (!fifo_full || pop);
    drop       = s1_valid_reg && fifo_full && !pop;
    head       = fifo_mem[rd_ptr_reg];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {s1_addr_reg, s1_data_reg};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in || start) begin
      // start behaves like reset for everything but the storage array:
      // pending entries are discarded and a coincident in_valid is ignored.
      s1_valid_reg <= 1'b0;
      s1_addr_reg  <= '0;
      s1_data_reg  <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
      count_reg    <= '0;
      done_reg     <= 1'b0;
    end else begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_addr_reg <= addr_calc;
        s1_data_reg <= data_calc;
      end

      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;

      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase

      if (drop) overflow_reg <= 1'b1;

      // Counter freezes once the map is complete.
      if (pop && !done_reg) begin
        count_reg <= count_reg + 1'b1;
        if (count_reg == CNT_W'(TOTAL - 1)) done_reg <= 1'b1;
      end
    end
  end

  // Head is gated so the outputs read zero while the FIFO is empty.
  always_comb begin
    mem_we     = !fifo_empty;
    mem_addr   = fifo_empty ? '0 : head[ENTRY_W-1 -: ADDR_W];
    mem_wdata  = fifo_empty ? '0 : head[EXT_MEM_WIDTH-1:0];
    fifo_level = level_reg;
    overflow   = overflow_reg;
    done       = done_reg;
  end

endmodule

// File: tb/tb_output_writeback.sv
// Testbench for output_writeback: directed vectors, expected writes queued in
// a scoreboard and checked by an independent write monitor.
module tb_output_writeback;

  localparam int FMW   = 8;
  localparam int FMH   = 4;
  localparam int CH    = 32;
  localparam int BASE  = 256;
  localparam int DEPTH = 8;
  localparam int TOTAL = FMW * FMH * CH;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        start;
  logic [31:0] in_data;
  logic        in_valid;
  logic [2:0]  in_x;
  logic [1:0]  in_y;
  logic [4:0]  in_ch;
  logic        mem_we;
  logic [19:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic        done;

  output_writeback #(
    .ACCUMULATION_WIDTH(32), .EXT_MEM_HEIGHT(1 << 20), .EXT_MEM_WIDTH(32),
    .FEATURE_MAP_WIDTH(FMW), .FEATURE_MAP_HEIGHT(FMH), .OUTPUT_NB_CHANNELS(CH),
    .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_in(rst_in), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .fifo_level(fifo_level), .overflow(overflow),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  n_wr = 0;
  int  last_pop_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] ea(input int x, input int y, input int ch);
    return 20'(BASE + (y * FMW + x) * CH + ch);
  endfunction

  function automatic logic [31:0] ed(input logic [31:0] d);
`ifdef WRITEBACK_RELU_EN
    return d[31] ? 32'd0 : d;
`else
    return d;
`endif
  endfunction

  // Monitor: every accepted write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_in && mem_we && mem_ready) begin
      n_wr++;
      last_pop_cyc = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_write", 64'(mem_addr), 64'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(e.addr));
        chk("wr_data", 64'(mem_wdata), 64'(e.data));
        $display("write addr=0x%05h data=0x%08h", mem_addr, mem_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int x, input int y, input int ch, input logic [31:0] d, input bit keep);
    in_valid = 1'b1;
    in_x     = 3'(x);
    in_y     = 2'(y);
    in_ch    = 5'(ch);
    in_data  = d;
    if (keep) sb.push_back('{ea(x, y, ch), ed(d)});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    sb.delete();
  endtask

  task automatic drain(input int budget);
    int i;
    mem_ready = 1'b1;
    for (i = 0; i < budget; i++) begin
      tick();
      if (fifo_level == 0 && !mem_we && sb.size() == 0) break;
    end
    chk("drain_timeout", 64'(i < budget), 64'd1);
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst_in = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    in_x = '0; in_y = '0; in_ch = '0; mem_ready = 1'b1;
    tick(); tick();
    chk("rst_mem_we", 64'(mem_we), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_mem_wdata", 64'(mem_wdata), 0);
    chk("rst_level", 64'(fifo_level), 0);
    chk("rst_overflow", 64'(overflow), 0);
    chk("rst_done", 64'(done), 0);
    rst_in = 1'b0;
    tick();

    // Single result, latency 2 cycles: addr BASE+34, data -5.
    put(1, 0, 2, 32'hFFFF_FFFB, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("lat_we_n1", 64'(mem_we), 0);
    tick();
    chk("lat_we_n2", 64'(mem_we), 1);
    chk("lat_addr", 64'(mem_addr), 64'(BASE + 34));
    drain(20);

    // Full map back-to-back.
    pulse_start();
    chk("start_done_clr", 64'(done), 0);
    n_wr = 0;
    for (int y = 0; y < FMH; y++)
      for (int x = 0; x < FMW; x++)
        for (int c = 0; c < CH; c++) begin
          put(x, y, c, 32'(((y * FMW + x) * CH + c) * 7 - 300), 1'b1);
          tick();
        end
    in_valid = 1'b0;
    begin
      int k;
      for (k = 0; k < 20; k++) begin
        @(negedge clk);
        if (done) break;
      end
      chk("map_done_seen", 64'(k < 20), 1);
      chk("map_done_timing", 64'(cyc), 64'(last_pop_cyc + 1));
    end
    chk("map_writes", 64'(n_wr), 64'(TOTAL));
    chk("map_overflow", 64'(overflow), 0);
    chk("map_sb_empty", 64'(sb.size()), 0);
    tick();

    // Overflow: 9 results into a stalled FIFO, 9th dropped.
    pulse_start();
    chk("start2_done_clr", 64'(done), 0);
    mem_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      put(i % FMW, 2, i, 32'(1000 + i), i < 8);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    chk("ovf_level", 64'(fifo_level), 8);
    chk("ovf_flag", 64'(overflow), 1);
    chk("ovf_stall_we", 64'(mem_we), 1);
    chk("ovf_stall_addr", 64'(mem_addr), 64'(ea(0, 2, 0)));
    drain(40);
    chk("ovf_sticky", 64'(overflow), 1);

    // start with 5 pending entries and a coincident in_valid.
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put(i, 3, 31, 32'(i), 1'b0);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    chk("st_level_before", 64'(fifo_level), 5);
    put(7, 3, 7, 32'h55, 1'b0);
    pulse_start();
    chk("st_level", 64'(fifo_level), 0);
    chk("st_we", 64'(mem_we), 0);
    chk("st_overflow", 64'(overflow), 0);
    chk("st_done", 64'(done), 0);
    mem_ready = 1'b1;
    tick(); tick(); tick();
    chk("st_no_write", 64'(mem_we), 0);

    // Full FIFO with continuous input and mem_ready high: no drops.
    mem_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i == 9) mem_ready = 1'b1;
      put(i % FMW, 1, i, 32'(-i), 1'b1);
      if (i >= 9) chk("full_level", 64'(fifo_level), 8);
      tick();
    end
    in_valid = 1'b0;
    chk("full_overflow", 64'(overflow), 0);
    drain(40);
    chk("full_overflow_end", 64'(overflow), 0);

    // Reset while a write is pending, then a fresh result.
    mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      put(i % FMW, 0, i, 32'(i), 1'b0);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    chk("pre_rst_we", 64'(mem_we), 1);
    chk("pre_rst_ovf", 64'(overflow), 1);
    rst_in = 1'b1;
    tick();
    sb.delete();
    chk("mrst_we", 64'(mem_we), 0);
    chk("mrst_addr", 64'(mem_addr), 0);
    chk("mrst_wdata", 64'(mem_wdata), 0);
    chk("mrst_level", 64'(fifo_level), 0);
    chk("mrst_overflow", 64'(overflow), 0);
    chk("mrst_done", 64'(done), 0);
    rst_in = 1'b0;
    mem_ready = 1'b1;
    tick();
    put(5, 3, 17, 32'h8000_0001, 1'b1);
    tick();
    put(6, 1, 3, 32'h0000_1234, 1'b1);
    tick();
    in_valid = 1'b0;
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
